bypass_data_path: RTL and testbench
===================================

BYPASS_DATA_PATH -- requirements
Module: bypass_data_path

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset.
REQ-002 SHALL have the following forward-control inputs. Bit0 selects the producer 1 instruction back, bit1 the producer 2 back, bit2 the producer 3 back.
- Fwd2ALU_opA_ctl  in  3  ALU operand A.
- Fwd2ALU_opB_ctl  in  3  ALU operand B.
- Fwd2ALU_MemWrite_ctl  in  3  store data.
- Fwd2Cmp_opA_ctl  in  3  compare operand A.
- Fwd2Cmp_opB_ctl  in  3  compare operand B.
REQ-003 SHALL have the following data inputs.
- RegA_in  in  32  register-file rs value.
- RegB_in  in  32  register-file rt value.
- ExeResult  in  32  result of the 1-back producer.
- ExeIsLoad  in  1  the 1-back producer is a load; ExeResult is not valid.
- MemResult  in  32  result of the 2-back producer, including load data.
- WbResult  in  32  result of the 3-back producer.
- Advance  in  1  pipeline enable; when low, all state and outputs hold.
REQ-004 SHALL have the following outputs, all registered.
- ALU_opA  out  32  forwarded ALU operand A.
- ALU_opB  out  32  forwarded ALU operand B.
- MemWriteData  out  32  forwarded store data.
- Cmp_opA  out  32  forwarded compare operand A.
- Cmp_opB  out  32  forwarded compare operand B.
- Stall  out  1  load-use bubble request.

Function
REQ-005 SHALL select, per operand, by fixed priority: bit0 -> ExeResult, else bit1 -> MemResult, else bit2 -> WbResult, else RegA_in (A/Cmp A) or RegB_in (B/MemWrite/Cmp B).
REQ-006 SHALL register every selected value, so outputs reflect inputs sampled at edge n on the cycle after edge n (latency 1).
REQ-007 SHALL implement an FSM with states RUN and STALL; the reset state is RUN.
REQ-008 In RUN with Advance=1, a load-use hit SHALL cause a transition to STALL, set Stall=1 and hold all operand outputs. A load-use hit is any operand's ctl bit0=1 while ExeIsLoad=1.
REQ-009 In STALL with Advance=1, the block SHALL use the ctl vectors latched at the hit, shifted one distance older, as the select:
- old bit0 -> distance 2 (MemResult);
- old bit1 -> distance 3 (WbResult);
- old bit2 -> register file.
It SHALL load the outputs, clear Stall and return to RUN.
REQ-010 While in STALL, the live ctl inputs and ExeIsLoad SHALL be ignored, so a second consecutive stall is impossible.
REQ-011 SHALL NOT stall when ctl bit1 or bit2 selects a load producer, because MemResult and WbResult are always valid.
REQ-012 With Advance=0, state, Stall and all outputs SHALL hold, including during STALL.
REQ-013 An all-zero ctl SHALL pass the register-file value; multi-hot ctl SHALL resolve by REQ-005 priority.

Reset
REQ-014 RESET low SHALL immediately clear all five 32-bit outputs to 0, Stall to 0, the latched ctl vectors to 0, and the state to RUN, including mid-STALL.
REQ-015 The first edge after RESET deasserts SHALL behave as RUN.

Configuration
REQ-016 Macro FWD_CMP_EN: when defined, Cmp_opA and Cmp_opB SHALL forward per REQ-005 and their bit0 SHALL participate in the load-use hit.
REQ-017 When FWD_CMP_EN is undefined, Cmp_opA and Cmp_opB SHALL be RegA_in and RegB_in registered; Fwd2Cmp_* SHALL be ignored and SHALL NOT cause a stall.

Structure
REQ-018 Package bypass_pkg SHALL hold:
- DATA_W=32;
- the state enum (RUN, STALL);
- the distance constants DIST1/DIST2/DIST3 (bit indices 0/1/2).
REQ-019 Sub-module bypass_sel3 (3-bit ctl, four 32-bit sources, priority select) SHALL be instantiated once per operand.

Verification
REQ-020 opA ctl=001, ExeResult=0x11, MemResult=0x22, ExeIsLoad=0 -> ALU_opA=0x11 next cycle, Stall=0.
REQ-021 opB ctl=110, MemResult=0x22, WbResult=0x33 -> ALU_opB=0x22; with ctl=000 and RegB_in=0x44 -> 0x44.
REQ-022 opA ctl=001, ExeIsLoad=1 -> Stall=1 for exactly 1 cycle with ALU_opA held; the next cycle, with MemResult=0xAB, ALU_opA=0xAB and Stall=0.
REQ-023 During STALL, Advance=0 for 3 cycles -> Stall stays 1 and outputs are frozen; releasing Advance completes REQ-022 unchanged.
REQ-024 RESET asserted in STALL -> all outputs 0 and Stall 0 asynchronously; after release, ctl=000 and RegA_in=0x5 -> ALU_opA=0x5.
REQ-025 FWD_CMP_EN undefined, Cmp opA ctl=001, ExeIsLoad=1 -> no stall, Cmp_opA=RegA_in.

Source files
------------

// File: rtl/bypass_pkg.sv
// Shared types and constants for the operand bypass network.
// Distance constants index the forwarding-control bits (1, 2, 3 instructions back).
package bypass_pkg;

    localparam int DATA_W = 32;
    localparam int CTL_W  = 3;
    localparam int N_OPS  = 5;

    localparam int DIST1 = 0;
    localparam int DIST2 = 1;
    localparam int DIST3 = 2;

    localparam int OP_ALU_A = 0;
    localparam int OP_ALU_B = 1;
    localparam int OP_MEMW  = 2;
    localparam int OP_CMP_A = 3;
    localparam int OP_CMP_B = 4;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // After a one-cycle bubble every producer is one step older, so the select moves up one bit.
    function automatic logic [CTL_W-1:0] shift_older(input logic [CTL_W-1:0] ctl);
        logic [CTL_W-1:0] res;
        res = ctl << 2'd1;
        return res;
    endfunction

endpackage

// File: rtl/bypass_sel3.sv
// Priority select of one operand: nearest producer wins, register file is the fallback.
module bypass_sel3
    import bypass_pkg::*;
(
    input  logic [CTL_W-1:0]  ctl,
    input  logic [DATA_W-1:0] exe_val,
    input  logic [DATA_W-1:0] mem_val,
    input  logic [DATA_W-1:0] wb_val,
    input  logic [DATA_W-1:0] reg_val,
    output logic [DATA_W-1:0] sel_val
);

    // Fixed-priority source selection
    always_comb begin
        sel_val = reg_val;
        if (ctl[DIST1]) begin
            sel_val = exe_val;
        end else if (ctl[DIST2]) begin
            sel_val = mem_val;
        end else if (ctl[DIST3]) begin
            sel_val = wb_val;
        end else begin
            sel_val = reg_val;
        end
    end

endmodule

// File: rtl/bypass_data_path.sv
// Registered operand forwarding with a one-cycle load-use bubble (RUN/STALL FSM).
// Optional macro FWD_CMP_EN enables forwarding and load-use detection on compare operands.
module bypass_data_path
    import bypass_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [CTL_W-1:0]  Fwd2ALU_opA_ctl,
    input  logic [CTL_W-1:0]  Fwd2ALU_opB_ctl,
    input  logic [CTL_W-1:0]  Fwd2ALU_MemWrite_ctl,
    input  logic [CTL_W-1:0]  Fwd2Cmp_opA_ctl,
    input  logic [CTL_W-1:0]  Fwd2Cmp_opB_ctl,
    input  logic [DATA_W-1:0] RegA_in,
    input  logic [DATA_W-1:0] RegB_in,
    input  logic [DATA_W-1:0] ExeResult,
    input  logic              ExeIsLoad,
    input  logic [DATA_W-1:0] MemResult,
    input  logic [DATA_W-1:0] WbResult,
    input  logic              Advance,
    output logic [DATA_W-1:0] ALU_opA,
    output logic [DATA_W-1:0] ALU_opB,
    output logic [DATA_W-1:0] MemWriteData,
    output logic [DATA_W-1:0] Cmp_opA,
    output logic [DATA_W-1:0] Cmp_opB,
    output logic              Stall
);

    state_t             state_r;
    logic [CTL_W-1:0]   live_ctl_s  [N_OPS];
    logic [CTL_W-1:0]   latch_ctl_r [N_OPS];
    logic [CTL_W-1:0]   use_ctl_s   [N_OPS];
    logic [DATA_W-1:0]  reg_src_s   [N_OPS];
    logic [DATA_W-1:0]  sel_s       [N_OPS];
    logic               hit_s;

    assign live_ctl_s[OP_ALU_A] = Fwd2ALU_opA_ctl;
    assign live_ctl_s[OP_ALU_B] = Fwd2ALU_opB_ctl;
    assign live_ctl_s[OP_MEMW]  = Fwd2ALU_MemWrite_ctl;

`ifdef FWD_CMP_EN
    assign live_ctl_s[OP_CMP_A] = Fwd2Cmp_opA_ctl;
    assign live_ctl_s[OP_CMP_B] = Fwd2Cmp_opB_ctl;
`else
    // Compare operands come straight from the register file in this build.
    logic unused_cmp_ctl_s;
    assign unused_cmp_ctl_s     = ^{Fwd2Cmp_opA_ctl, Fwd2Cmp_opB_ctl};
    assign live_ctl_s[OP_CMP_A] = 3'b000;
    assign live_ctl_s[OP_CMP_B] = 3'b000;
`endif

    assign reg_src_s[OP_ALU_A] = RegA_in;
    assign reg_src_s[OP_ALU_B] = RegB_in;
    assign reg_src_s[OP_MEMW]  = RegB_in;
    assign reg_src_s[OP_CMP_A] = RegA_in;
    assign reg_src_s[OP_CMP_B] = RegB_in;

    // Load-use hazard: any operand wants the 1-back result while it is still a pending load
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < N_OPS; i++) begin
            hit_s = hit_s | live_ctl_s[i][DIST1];
        end
        hit_s = hit_s & ExeIsLoad;
    end

    // Select source: live controls in RUN, aged latched controls while completing a bubble
    always_comb begin
        for (int i = 0; i < N_OPS; i++) begin
            if (state_r == STALL) begin
                use_ctl_s[i] = shift_older(latch_ctl_r[i]);
            end else begin
                use_ctl_s[i] = live_ctl_s[i];
            end
        end
    end

    for (genvar g = 0; g < N_OPS; g++) begin : g_sel
        bypass_sel3 u_sel (
            .ctl     (use_ctl_s[g]),
            .exe_val (ExeResult),
            .mem_val (MemResult),
            .wb_val  (WbResult),
            .reg_val (reg_src_s[g]),
            .sel_val (sel_s[g])
        );
    end

    // FSM, latched controls and registered operand outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r      <= RUN;
            Stall        <= 1'b0;
            ALU_opA      <= 32'h0000_0000;
            ALU_opB      <= 32'h0000_0000;
            MemWriteData <= 32'h0000_0000;
            Cmp_opA      <= 32'h0000_0000;
            Cmp_opB      <= 32'h0000_0000;
            for (int i = 0; i < N_OPS; i++) begin
                latch_ctl_r[i] <= 3'b000;
            end
        end else if (Advance) begin
            case (state_r)
                RUN: begin
                    if (hit_s) begin
                        state_r <= STALL;
                        Stall   <= 1'b1;
                        for (int i = 0; i < N_OPS; i++) begin
                            latch_ctl_r[i] <= live_ctl_s[i];
                        end
                    end else begin
                        Stall        <= 1'b0;
                        ALU_opA      <= sel_s[OP_ALU_A];
                        ALU_opB      <= sel_s[OP_ALU_B];
                        MemWriteData <= sel_s[OP_MEMW];
                        Cmp_opA      <= sel_s[OP_CMP_A];
                        Cmp_opB      <= sel_s[OP_CMP_B];
                    end
                end
                STALL: begin
                    state_r      <= RUN;
                    Stall        <= 1'b0;
                    ALU_opA      <= sel_s[OP_ALU_A];
                    ALU_opB      <= sel_s[OP_ALU_B];
                    MemWriteData <= sel_s[OP_MEMW];
                    Cmp_opA      <= sel_s[OP_CMP_A];
                    Cmp_opB      <= sel_s[OP_CMP_B];
                end
                default: begin
                    state_r <= RUN;
                    Stall   <= 1'b0;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: tb/tb_bypass_data_path.sv
// Directed self-checking bench for bypass_data_path: forwarding priority, load-use bubble,
// Advance hold, and asynchronous reset during a bubble.
module tb_bypass_data_path;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [2:0]  Fwd2ALU_opA_ctl, Fwd2ALU_opB_ctl, Fwd2ALU_MemWrite_ctl;
    logic [2:0]  Fwd2Cmp_opA_ctl, Fwd2Cmp_opB_ctl;
    logic [31:0] RegA_in, RegB_in, ExeResult, MemResult, WbResult;
    logic        ExeIsLoad, Advance;
    logic [31:0] ALU_opA, ALU_opB, MemWriteData, Cmp_opA, Cmp_opB;
    logic        Stall;

    int errors = 0;
    int checks = 0;

    bypass_data_path dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .Fwd2ALU_opA_ctl      (Fwd2ALU_opA_ctl),
        .Fwd2ALU_opB_ctl      (Fwd2ALU_opB_ctl),
        .Fwd2ALU_MemWrite_ctl (Fwd2ALU_MemWrite_ctl),
        .Fwd2Cmp_opA_ctl      (Fwd2Cmp_opA_ctl),
        .Fwd2Cmp_opB_ctl      (Fwd2Cmp_opB_ctl),
        .RegA_in              (RegA_in),
        .RegB_in              (RegB_in),
        .ExeResult            (ExeResult),
        .ExeIsLoad            (ExeIsLoad),
        .MemResult            (MemResult),
        .WbResult             (WbResult),
        .Advance              (Advance),
        .ALU_opA              (ALU_opA),
        .ALU_opB              (ALU_opB),
        .MemWriteData         (MemWriteData),
        .Cmp_opA              (Cmp_opA),
        .Cmp_opB              (Cmp_opB),
        .Stall                (Stall)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ctl(input logic [2:0] a, input logic [2:0] b, input logic [2:0] w,
                           input logic [2:0] ca, input logic [2:0] cb);
        Fwd2ALU_opA_ctl      = a;
        Fwd2ALU_opB_ctl      = b;
        Fwd2ALU_MemWrite_ctl = w;
        Fwd2Cmp_opA_ctl      = ca;
        Fwd2Cmp_opB_ctl      = cb;
    endtask

    initial begin
        RESET = 1'b0;
        Advance = 1'b1;
        ExeIsLoad = 1'b0;
        set_ctl(3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        RegA_in = 32'h0; RegB_in = 32'h0;
        ExeResult = 32'h0; MemResult = 32'h0; WbResult = 32'h0;

        // Reset state
        #3;
        check("rst_alu_a", ALU_opA, 32'h0);
        check("rst_alu_b", ALU_opB, 32'h0);
        check("rst_memw", MemWriteData, 32'h0);
        check("rst_cmp_a", Cmp_opA, 32'h0);
        check("rst_cmp_b", Cmp_opB, 32'h0);
        check("rst_stall", {31'd0, Stall}, 32'h0);
        #9;
        RESET = 1'b1;

        // Basic forwarding, priority across distances
        ExeResult = 32'h11; MemResult = 32'h22; WbResult = 32'h33;
        RegA_in = 32'hA0; RegB_in = 32'hB0;
        set_ctl(3'b001, 3'b110, 3'b100, 3'b010, 3'b000);
        tick();
        check("fwd_exe_a", ALU_opA, 32'h11);
        check("fwd_prio_b", ALU_opB, 32'h22);
        check("fwd_wb_memw", MemWriteData, 32'h33);
`ifdef FWD_CMP_EN
        check("cmp_a_fwd", Cmp_opA, 32'h22);
`else
        check("cmp_a_reg", Cmp_opA, 32'hA0);
`endif
        check("cmp_b_reg", Cmp_opB, 32'hB0);
        check("fwd_stall", {31'd0, Stall}, 32'h0);

        // Register-file pass-through and multi-hot priority; outputs must lag inputs by one edge
        RegB_in = 32'h44;
        set_ctl(3'b111, 3'b000, 3'b011, 3'b000, 3'b000);
        #1;
        check("latency_hold_b", ALU_opB, 32'h22);
        tick();
        check("reg_pass_b", ALU_opB, 32'h44);
        check("multihot_a", ALU_opA, 32'h11);
        check("multihot_memw", MemWriteData, 32'h11);
        check("cmp_a_zero", Cmp_opA, 32'hA0);

        // Load-use bubble: hold, then re-select with aged controls
        ExeIsLoad = 1'b1; ExeResult = 32'h99; MemResult = 32'h55;
        set_ctl(3'b001, 3'b010, 3'b000, 3'b000, 3'b000);
        tick();
        check("lu_stall", {31'd0, Stall}, 32'h1);
        check("lu_hold_a", ALU_opA, 32'h11);
        check("lu_hold_b", ALU_opB, 32'h44);
        check("lu_hold_memw", MemWriteData, 32'h11);
        MemResult = 32'hAB; WbResult = 32'hCD;
        set_ctl(3'b000, 3'b000, 3'b001, 3'b000, 3'b000);
        tick();
        check("lu_done_a", ALU_opA, 32'hAB);
        check("lu_done_b", ALU_opB, 32'hCD);
        check("lu_done_memw", MemWriteData, 32'h44);
        check("lu_done_stall", {31'd0, Stall}, 32'h0);

        // Compare operand with a pending load
        ExeIsLoad = 1'b1; RegA_in = 32'h77;
        set_ctl(3'b000, 3'b000, 3'b000, 3'b001, 3'b000);
        tick();
`ifdef FWD_CMP_EN
        check("cmp_lu_stall", {31'd0, Stall}, 32'h1);
        check("cmp_lu_hold", Cmp_opA, 32'hA0);
`else
        check("cmp_no_stall", {31'd0, Stall}, 32'h0);
        check("cmp_reg_a", Cmp_opA, 32'h77);
`endif
        ExeIsLoad = 1'b0;
        set_ctl(3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        tick();
        check("post_cmp_a", ALU_opA, 32'h77);
        check("post_cmp_stall", {31'd0, Stall}, 32'h0);

        // Bubble frozen by Advance=0, live inputs changing meanwhile
        ExeIsLoad = 1'b1; MemResult = 32'h22;
        set_ctl(3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
        tick();
        check("adv_enter_stall", {31'd0, Stall}, 32'h1);
        Advance = 1'b0; MemResult = 32'hAB; ExeResult = 32'hEE;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("adv_hold_stall", {31'd0, Stall}, 32'h1);
            check("adv_hold_a", ALU_opA, 32'h77);
        end
        Advance = 1'b1;
        set_ctl(3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        tick();
        check("adv_done_a", ALU_opA, 32'hAB);
        check("adv_done_stall", {31'd0, Stall}, 32'h0);

        // Asynchronous reset in the middle of a bubble
        ExeIsLoad = 1'b1; ExeResult = 32'h12;
        set_ctl(3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
        tick();
        check("rst2_enter_stall", {31'd0, Stall}, 32'h1);
        #2;
        RESET = 1'b0;
        #1;
        check("rst2_alu_a", ALU_opA, 32'h0);
        check("rst2_alu_b", ALU_opB, 32'h0);
        check("rst2_memw", MemWriteData, 32'h0);
        check("rst2_cmp_a", Cmp_opA, 32'h0);
        check("rst2_cmp_b", Cmp_opB, 32'h0);
        check("rst2_stall", {31'd0, Stall}, 32'h0);
        ExeIsLoad = 1'b0; RegA_in = 32'h5; MemResult = 32'h66;
        set_ctl(3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        #2;
        RESET = 1'b1;
        tick();
        check("rst2_first_a", ALU_opA, 32'h5);
        check("rst2_first_stall", {31'd0, Stall}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
